a5_keystream_sequencer: RTL and testbench

- Control stage that sits directly upstream of three A5/1 LFSR instances (R1 19b, R2 22b, R3 23b) and downstream of the key scheduler.
- Drives each LFSR's load, clk_en and serial d inputs, and consumes each LFSR's q and clock-bit outputs.
- Sequences key load, frame load, mixing and majority-clocked keystream generation.
- Emits keystream one bit at a time over a valid/ready handshake.

---
 rtl/a5_keystream_sequencer.sv | 176 +++++++++++++++++
 tb/tb_a5_keystream_sequencer.sv | 284 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/a5_keystream_sequencer.sv
// rtl/a5_keystream_sequencer.sv - A5/1 key/frame load, mixing and majority-clocked keystream control
module a5_keystream_sequencer #(
    parameter int KEY_BITS   = 64,
    parameter int FRAME_BITS = 22,
    parameter int MIX_CYCLES = 100,
    parameter int KS_BITS    = 228
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic                  abort,
    input  logic [KEY_BITS-1:0]   key_i,
    input  logic [FRAME_BITS-1:0] frame_i,
    output logic                  busy,
    output logic                  done,
    output logic                  lfsr_load,
    output logic [2:0]            lfsr_clk_en,
    output logic                  lfsr_d,
    input  logic [2:0]            lfsr_q,
    input  logic [2:0]            lfsr_clk_bit,
    output logic                  ks_bit,
    output logic                  ks_valid,
    input  logic                  ks_ready
);

    localparam int MAX_A   = (KEY_BITS > FRAME_BITS) ? KEY_BITS : FRAME_BITS;
    localparam int MAX_B   = (MIX_CYCLES + 1 > KS_BITS) ? MIX_CYCLES + 1 : KS_BITS;
    localparam int MAX_LEN = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int CNT_W   = $clog2(MAX_LEN) + 1;

    localparam logic [CNT_W-1:0] KEY_LAST   = CNT_W'(KEY_BITS - 1);
    localparam logic [CNT_W-1:0] FRAME_LAST = CNT_W'(FRAME_BITS - 1);
    localparam logic [CNT_W-1:0] MIX_LAST   = CNT_W'(MIX_CYCLES);
    localparam logic [CNT_W-1:0] KS_LAST    = CNT_W'(KS_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_KEY,
        S_FRAME,
        S_MIX,
        S_STREAM
    } state_t;

    state_t                  state_q, state_d;
    logic [CNT_W-1:0]        cnt_q, cnt_d;
    logic [KEY_BITS-1:0]     key_sh_q, key_sh_d;
    logic [FRAME_BITS-1:0]   frame_sh_q, frame_sh_d;
    logic                    busy_q, ks_valid_q, load_q;
    logic                    maj;
    logic [2:0]              maj_en;

    // Registers whose clock bit agrees with the majority step; at least two always do.
    assign maj    = (lfsr_clk_bit[0] & lfsr_clk_bit[1]) |
                    (lfsr_clk_bit[0] & lfsr_clk_bit[2]) |
                    (lfsr_clk_bit[1] & lfsr_clk_bit[2]);
    assign maj_en = ~(lfsr_clk_bit ^ {3{maj}});

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        key_sh_d   = key_sh_q;
        frame_sh_d = frame_sh_q;
        if (abort) begin
            state_d = S_IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d    = S_LOAD;
                        cnt_d      = '0;
                        key_sh_d   = key_i;
                        frame_sh_d = frame_i;
                    end
                end
                S_LOAD: begin
                    state_d = S_KEY;
                    cnt_d   = '0;
                end
                S_KEY: begin
                    key_sh_d = key_sh_q >> 1;
                    if (cnt_q == KEY_LAST) begin
                        state_d = S_FRAME;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_FRAME: begin
                    frame_sh_d = frame_sh_q >> 1;
                    if (cnt_q == FRAME_LAST) begin
                        state_d = S_MIX;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_MIX: begin
                    if (cnt_q == MIX_LAST) begin
                        state_d = S_STREAM;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                S_STREAM: begin
                    if (ks_ready) begin
                        if (cnt_q == KS_LAST) begin
                            state_d = S_IDLE;
                            cnt_d   = '0;
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= '0;
            key_sh_q   <= '0;
            frame_sh_q <= '0;
            busy_q     <= 1'b0;
            ks_valid_q <= 1'b0;
            load_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            key_sh_q   <= key_sh_d;
            frame_sh_q <= frame_sh_d;
            busy_q     <= (state_d != S_IDLE);
            ks_valid_q <= (state_d == S_STREAM);
            load_q     <= (state_d == S_LOAD);
        end
    end

    // Shadow registers shift right, so bit 0 always holds the next bit to feed.
    always_comb begin
        lfsr_clk_en = 3'b000;
        lfsr_d      = 1'b0;
        if (!abort) begin
            case (state_q)
                S_KEY: begin
                    lfsr_clk_en = 3'b111;
                    lfsr_d      = key_sh_q[0];
                end
                S_FRAME: begin
                    lfsr_clk_en = 3'b111;
                    lfsr_d      = frame_sh_q[0];
                end
                S_MIX: lfsr_clk_en = maj_en;
                S_STREAM: begin
                    if (ks_ready && (cnt_q != KS_LAST)) begin
                        lfsr_clk_en = maj_en;
                    end
                end
                default: lfsr_clk_en = 3'b000;
            endcase
        end
    end

    assign done      = (state_q == S_STREAM) && ks_ready && (cnt_q == KS_LAST) && !abort;
    assign busy      = busy_q;
    assign ks_valid  = ks_valid_q;
    assign lfsr_load = load_q;
    assign ks_bit    = ^lfsr_q;

endmodule

// File: tb/tb_a5_keystream_sequencer.sv
// tb/tb_a5_keystream_sequencer.sv - self-checking bench with behavioural A5/1 registers
module tb_a5_keystream_sequencer;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic        ks_ready = 1'b0;
    logic [63:0] key_i = '0;
    logic [21:0] frame_i = '0;
    logic        busy, done, lfsr_load, lfsr_d, ks_bit, ks_valid;
    logic [2:0]  lfsr_clk_en, lfsr_q, lfsr_clk_bit;

    logic [18:0] r1;
    logic [21:0] r2;
    logic [22:0] r3;

    int checks = 0;
    int errors = 0;
    int done_cnt = 0;
    int excl_viol = 0;
    int maj_viol = 0;
    int stall_viol = 0;

    localparam logic [63:0]  KNOWN_KEY   = 64'hEFCDAB8967452312;
    localparam logic [21:0]  KNOWN_FRAME = 22'h134;
    localparam logic [119:0] KNOWN_A     = 120'h534EAA582FE8151AB6E1855A728C00;
    localparam logic [119:0] KNOWN_B     = 120'h24FD35A35D5FB6526D32F906DF1AC0;

    typedef struct {
        logic [63:0]  key;
        logic [21:0]  frame;
        bit           bp;
        logic [119:0] exp_a;
        logic [119:0] exp_b;
    } vec_t;

    vec_t vecs[3];

    always #5 clk = ~clk;

    a5_keystream_sequencer dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .start        (start),
        .abort        (abort),
        .key_i        (key_i),
        .frame_i      (frame_i),
        .busy         (busy),
        .done         (done),
        .lfsr_load    (lfsr_load),
        .lfsr_clk_en  (lfsr_clk_en),
        .lfsr_d       (lfsr_d),
        .lfsr_q       (lfsr_q),
        .lfsr_clk_bit (lfsr_clk_bit),
        .ks_bit       (ks_bit),
        .ks_valid     (ks_valid),
        .ks_ready     (ks_ready)
    );

    // A5/1 registers: R1 taps 18,17,16,13; R2 taps 21,20; R3 taps 22,21,20,7.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else if (lfsr_load) begin
            r1 <= '0;
            r2 <= '0;
            r3 <= '0;
        end else begin
            if (lfsr_clk_en[0]) r1 <= {r1[17:0], (^(r1 & 19'h72000)) ^ lfsr_d};
            if (lfsr_clk_en[1]) r2 <= {r2[20:0], (^(r2 & 22'h300000)) ^ lfsr_d};
            if (lfsr_clk_en[2]) r3 <= {r3[21:0], (^(r3 & 23'h700080)) ^ lfsr_d};
        end
    end

    assign lfsr_q       = {r3[22], r2[21], r1[18]};
    assign lfsr_clk_bit = {r3[10], r2[10], r1[8]};

    always @(negedge clk) begin
        #2;
        if (done) done_cnt++;
        if (lfsr_load && (lfsr_clk_en != 3'b000)) excl_viol++;
        if ($countones(lfsr_clk_en) == 1) maj_viol++;
    end

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic collect(input bit bp, input int nbits, output logic [113:0] a,
                           output logic [113:0] b, output int got);
        logic hold;
        logic hbit;
        int   cyc;
        a = '0;
        b = '0;
        got = 0;
        hold = 1'b0;
        hbit = 1'b0;
        cyc = 0;
        while (got < nbits && cyc < 6000) begin
            @(negedge clk);
            cyc++;
            ks_ready = bp ? ($urandom_range(0, 1) == 1) : 1'b1;
            #1;
            if (ks_valid) begin
                if (hold && (ks_bit !== hbit)) stall_viol++;
                if (ks_ready) begin
                    if (got < 114) a = {a[112:0], ks_bit};
                    else b = {b[112:0], ks_bit};
                    got++;
                    hold = 1'b0;
                end else begin
                    if (lfsr_clk_en !== 3'b000) stall_viol++;
                    hold = 1'b1;
                    hbit = ks_bit;
                end
            end
        end
    endtask

    task automatic check_stream(input string name, input logic [113:0] a, input logic [113:0] b,
                                input int got, input logic [119:0] ea, input logic [119:0] eb);
        check({name, "_count"}, 128'(got), 128'(228));
        check({name, "_first114"}, 128'(a), 128'(ea[119:6]));
        check({name, "_next114"}, 128'(b), 128'(eb[119:6]));
    endtask

    initial begin
        logic [113:0] a, b;
        int got, d0, load_cnt, load_k, en_cnt, first_valid;

        vecs[0] = '{key: KNOWN_KEY, frame: KNOWN_FRAME, bp: 1'b0, exp_a: KNOWN_A, exp_b: KNOWN_B};
        vecs[1] = '{key: KNOWN_KEY, frame: KNOWN_FRAME, bp: 1'b1, exp_a: KNOWN_A, exp_b: KNOWN_B};
        vecs[2] = '{key: 64'h0, frame: 22'h0, bp: 1'b0, exp_a: 120'h0, exp_b: 120'h0};

        repeat (3) @(negedge clk);
        #1;
        check("rst_busy", 128'(busy), 128'(0));
        check("rst_done", 128'(done), 128'(0));
        check("rst_load", 128'(lfsr_load), 128'(0));
        check("rst_clk_en", 128'(lfsr_clk_en), 128'(0));
        check("rst_d", 128'(lfsr_d), 128'(0));
        check("rst_ks_valid", 128'(ks_valid), 128'(0));
        reset_n = 1'b1;

        // start and abort together in IDLE: abort wins
        @(negedge clk);
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        #1;
        check("start_abort_idle_busy", 128'(busy), 128'(0));

        for (int i = 0; i < 3; i++) begin
            key_i = vecs[i].key;
            frame_i = vecs[i].frame;
            d0 = done_cnt;
            pulse_start();
            collect(vecs[i].bp, 228, a, b, got);
            @(negedge clk);
            ks_ready = 1'b0;
            #3;
            check_stream($sformatf("vec%0d", i), a, b, got, vecs[i].exp_a, vecs[i].exp_b);
            check($sformatf("vec%0d_done_once", i), 128'(done_cnt - d0), 128'(1));
            check($sformatf("vec%0d_idle_after", i), 128'(busy), 128'(0));
        end

        // timing and control profile with an all-zero key and frame
        key_i = '0;
        frame_i = '0;
        load_cnt = 0;
        load_k = 0;
        en_cnt = 0;
        first_valid = 0;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 200; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
            #1;
            if (lfsr_load) begin
                load_cnt++;
                load_k = k;
            end
            if (k <= 87 && lfsr_clk_en == 3'b111) en_cnt++;
            if (ks_valid && first_valid == 0) first_valid = k;
        end
        check("load_cycles", 128'(load_cnt), 128'(1));
        check("load_position", 128'(load_k), 128'(1));
        check("clk_en_111_cycles", 128'(en_cnt), 128'(86));
        check("ks_valid_latency", 128'(first_valid - 1), 128'(188));
        d0 = done_cnt;
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        #3;
        check("abort_stream_busy", 128'(busy), 128'(0));
        check("abort_stream_valid", 128'(ks_valid), 128'(0));
        check("abort_stream_no_done", 128'(done_cnt - d0), 128'(0));

        // reset after 10 accepted bits, then a clean replay
        key_i = KNOWN_KEY;
        frame_i = KNOWN_FRAME;
        pulse_start();
        collect(1'b0, 10, a, b, got);
        check("partial_prefix", 128'(a[9:0]), 128'(10'b0101001101));
        reset_n = 1'b0;
        #1;
        check("midreset_busy", 128'(busy), 128'(0));
        check("midreset_valid", 128'(ks_valid), 128'(0));
        @(negedge clk);
        reset_n = 1'b1;
        ks_ready = 1'b0;
        pulse_start();
        collect(1'b0, 228, a, b, got);
        @(negedge clk);
        ks_ready = 1'b0;
        check_stream("replay", a, b, got, KNOWN_A, KNOWN_B);

        // abort at MIX cycle 50, then restart
        d0 = done_cnt;
        @(negedge clk);
        start = 1'b1;
        for (int k = 1; k <= 138; k++) begin
            @(negedge clk);
            if (k == 1) start = 1'b0;
        end
        abort = 1'b1;
        #1;
        check("abort_mix_clk_en", 128'(lfsr_clk_en), 128'(0));
        @(negedge clk);
        abort = 1'b0;
        #1;
        check("abort_mix_busy", 128'(busy), 128'(0));
        check("abort_mix_valid", 128'(ks_valid), 128'(0));
        repeat (3) @(negedge clk);
        check("abort_mix_no_done", 128'(done_cnt - d0), 128'(0));
        pulse_start();
        collect(1'b0, 228, a, b, got);
        @(negedge clk);
        ks_ready = 1'b0;
        check_stream("after_abort", a, b, got, KNOWN_A, KNOWN_B);

        // second start with another key during KEY is ignored
        d0 = done_cnt;
        pulse_start();
        repeat (20) @(negedge clk);
        key_i = ~KNOWN_KEY;
        frame_i = ~KNOWN_FRAME;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        collect(1'b0, 228, a, b, got);
        @(negedge clk);
        ks_ready = 1'b0;
        #3;
        check_stream("restart_ignored", a, b, got, KNOWN_A, KNOWN_B);
        check("restart_done_once", 128'(done_cnt - d0), 128'(1));

        check("load_clk_en_exclusive", 128'(excl_viol), 128'(0));
        check("majority_popcount", 128'(maj_viol), 128'(0));
        check("stall_hold", 128'(stall_viol), 128'(0));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
